wb_queue_stage: RTL and testbench

WB_QUEUE_STAGE -- requirements
Module: wb_queue_stage

---
 rtl/wb_queue_stage.sv | 134 +++++++++++++
 tb/tb_wb_queue_stage.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_queue_stage.sv
// Writeback queue stage: buffers ALU/load results ahead of the register-file write port,
// with youngest-match forwarding. Define WB_LOAD_ALIGN_EN for load byte/half alignment (DATA_W=32).
module wb_queue_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_wb_en,
  input  logic                       in_mem_r_en,
  input  logic [DATA_W-1:0]          in_alu_result,
  input  logic [DATA_W-1:0]          in_mem_data,
  input  logic [ADDR_W-1:0]          in_dest,
  input  logic [1:0]                 in_size,
  input  logic                       in_signed,
  input  logic                       flush,
  output logic                       wb_en_out,
  output logic [ADDR_W-1:0]          wb_reg_dest_out,
  output logic [DATA_W-1:0]          wb_value_out,
  input  logic                       wb_gnt,
  input  logic [ADDR_W-1:0]          fwd_addr,
  output logic                       fwd_hit,
  output logic [DATA_W-1:0]          fwd_value,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

`ifdef WB_LOAD_ALIGN_EN
  // Lane select by low address bits, then sign/zero extension; word loads pass through.
  function automatic logic [DATA_W-1:0] align_load(input logic [DATA_W-1:0] data,
                                                  input logic [1:0]        lane,
                                                  input logic [1:0]        size,
                                                  input logic              sgn);
    logic [7:0]        b;
    logic [15:0]       h;
    logic [DATA_W-1:0] res;
    b = data[{lane, 3'b000} +: 8];
    h = lane[1] ? data[31:16] : data[15:0];
    case (size)
      2'b00:   res = {{(DATA_W-8){sgn & b[7]}}, b};
      2'b01:   res = {{(DATA_W-16){sgn & h[15]}}, h};
      default: res = data;
    endcase
    return res;
  endfunction
`else
  function automatic logic [DATA_W-1:0] align_load(input logic [DATA_W-1:0] data);
    return data;
  endfunction

  logic unused_align;
  assign unused_align = ^{in_size, in_signed};
`endif

  logic [DATA_W-1:0] q_val_p1  [DEPTH];
  logic [ADDR_W-1:0] q_dest_p1 [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_p1;
  logic [PTR_W-1:0]  rd_ptr_p1;
  logic [CNT_W-1:0]  count_p1;

  logic              vld_p0;
  logic              pop;
  logic [DATA_W-1:0] enq_val_p0;

  // Stage 0: enqueue decision and value selection
  assign in_ready  = (count_p1 != CNT_W'(DEPTH));
  assign vld_p0    = in_valid && in_ready && in_wb_en;
  assign wb_en_out = (count_p1 != '0);
  assign pop       = wb_en_out && wb_gnt;

  always_comb begin
    enq_val_p0 = in_alu_result;
    if (in_mem_r_en) begin
`ifdef WB_LOAD_ALIGN_EN
      enq_val_p0 = align_load(in_mem_data, in_alu_result[1:0], in_size, in_signed);
`else
      enq_val_p0 = align_load(in_mem_data);
`endif
    end
  end

  // Stage 1: queue storage and control state
  always_ff @(posedge clk) begin
    if (vld_p0 && !flush) begin
      q_val_p1[wr_ptr_p1]  <= enq_val_p0;
      q_dest_p1[wr_ptr_p1] <= in_dest;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_p1 <= '0;
      rd_ptr_p1 <= '0;
      count_p1  <= '0;
    end else if (flush) begin
      wr_ptr_p1 <= '0;
      rd_ptr_p1 <= '0;
      count_p1  <= '0;
    end else begin
      if (vld_p0) wr_ptr_p1 <= wr_ptr_p1 + PTR_W'(1);
      if (pop)    rd_ptr_p1 <= rd_ptr_p1 + PTR_W'(1);
      case ({vld_p0, pop})
        2'b10:   count_p1 <= count_p1 + CNT_W'(1);
        2'b01:   count_p1 <= count_p1 - CNT_W'(1);
        default: count_p1 <= count_p1;
      endcase
    end
  end

  assign count           = count_p1;
  assign wb_reg_dest_out = wb_en_out ? q_dest_p1[rd_ptr_p1] : '0;
  assign wb_value_out    = wb_en_out ? q_val_p1[rd_ptr_p1]  : '0;

  // Scan oldest to youngest so the last match seen is the youngest.
  always_comb begin
    logic [PTR_W-1:0] idx;
    fwd_hit   = 1'b0;
    fwd_value = '0;
    idx       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_p1 + PTR_W'(i);
      if ((CNT_W'(i) < count_p1) && (q_dest_p1[idx] == fwd_addr)) begin
        fwd_hit   = 1'b1;
        fwd_value = q_val_p1[idx];
      end
    end
  end

endmodule

// File: tb/tb_wb_queue_stage.sv
// Bench for wb_queue_stage: directed vectors, corner sequences and a randomized run
// against a queue-based reference model.
module tb_wb_queue_stage;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready, in_wb_en, in_mem_r_en;
  logic [31:0]       in_alu_result, in_mem_data;
  logic [3:0]        in_dest;
  logic [1:0]        in_size;
  logic              in_signed, flush;
  logic              wb_en_out;
  logic [3:0]        wb_reg_dest_out;
  logic [31:0]       wb_value_out;
  logic              wb_gnt;
  logic [3:0]        fwd_addr;
  logic              fwd_hit;
  logic [31:0]       fwd_value;
  logic [2:0]        count;

  always #5 clk = ~clk;

  wb_queue_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_wb_en(in_wb_en), .in_mem_r_en(in_mem_r_en), .in_alu_result(in_alu_result),
    .in_mem_data(in_mem_data), .in_dest(in_dest), .in_size(in_size),
    .in_signed(in_signed), .flush(flush), .wb_en_out(wb_en_out),
    .wb_reg_dest_out(wb_reg_dest_out), .wb_value_out(wb_value_out), .wb_gnt(wb_gnt),
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_value(fwd_value), .count(count)
  );

  typedef struct {
    logic [31:0] val;
    logic [3:0]  dest;
  } ent_t;
  ent_t mq[$];

  typedef struct {
    logic        mem_r_en;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] exp_on;
    logic [31:0] exp_off;
  } vec_t;
  vec_t vecs[10];

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] model_align(input logic [31:0] mem, input int addr,
                                              input logic [1:0] size, input logic sgn);
    logic [31:0] v;
    v = mem;
`ifdef WB_LOAD_ALIGN_EN
    if (size == 2'd0) begin
      v = (mem >> (addr * 8)) & 32'hFF;
      if (sgn && v >= 32'd128) v = v | 32'hFFFF_FF00;
    end else if (size == 2'd1) begin
      v = (mem >> ((addr / 2) * 16)) & 32'hFFFF;
      if (sgn && v >= 32'd32768) v = v | 32'hFFFF_0000;
    end
`endif
    return v;
  endfunction

  task automatic check_outputs();
    logic        h;
    logic [31:0] fv;
    h  = 1'b0;
    fv = 32'd0;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (!h && mq[i].dest == fwd_addr) begin
        h  = 1'b1;
        fv = mq[i].val;
      end
    end
    chk("count", 32'(count), 32'(mq.size()));
    chk("wb_en_out", 32'(wb_en_out), 32'(mq.size() > 0));
    chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
    chk("wb_dest", 32'(wb_reg_dest_out), (mq.size() > 0) ? 32'(mq[0].dest) : 32'd0);
    chk("wb_value", wb_value_out, (mq.size() > 0) ? mq[0].val : 32'd0);
    chk("fwd_hit", 32'(fwd_hit), 32'(h));
    chk("fwd_value", fwd_value, fv);
  endtask

  // One clock edge: model the transfer decisions from pre-edge state, then compare.
  task automatic tick();
    logic do_push, do_pop;
    ent_t e;
    do_push = in_valid && (mq.size() < DEPTH) && in_wb_en;
    do_pop  = (mq.size() > 0) && wb_gnt;
    e.dest  = in_dest;
    e.val   = in_mem_r_en ? model_align(in_mem_data, int'(in_alu_result[1:0]), in_size, in_signed)
                          : in_alu_result;
    @(posedge clk);
    if (!rst || flush) mq.delete();
    else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(e);
    end
    #1;
    check_outputs();
  endtask

  task automatic set_idle();
    in_valid = 0; in_wb_en = 0; in_mem_r_en = 0; in_alu_result = 0; in_mem_data = 0;
    in_dest = 0; in_size = 0; in_signed = 0; flush = 0; wb_gnt = 0; fwd_addr = 0;
  endtask

  task automatic push_alu(input logic [3:0] d, input logic [31:0] v);
    in_valid = 1; in_wb_en = 1; in_mem_r_en = 0; in_dest = d; in_alu_result = v;
    tick();
    in_valid = 0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h2, 32'h80FF7F01, 2'd0, 1'b1, 32'hFFFFFFFF, 32'h80FF7F01};
    vecs[1] = '{1'b1, 32'h2, 32'h80FF7F01, 2'd1, 1'b0, 32'h000080FF, 32'h80FF7F01};
    vecs[2] = '{1'b1, 32'h0, 32'h80FF7F01, 2'd0, 1'b0, 32'h00000001, 32'h80FF7F01};
    vecs[3] = '{1'b1, 32'h3, 32'h80FF7F01, 2'd0, 1'b1, 32'hFFFFFF80, 32'h80FF7F01};
    vecs[4] = '{1'b1, 32'h1, 32'h80FF7F01, 2'd0, 1'b1, 32'h0000007F, 32'h80FF7F01};
    vecs[5] = '{1'b1, 32'h0, 32'h80FF7F01, 2'd1, 1'b1, 32'h00007F01, 32'h80FF7F01};
    vecs[6] = '{1'b1, 32'h2, 32'h80FF7F01, 2'd1, 1'b1, 32'hFFFF80FF, 32'h80FF7F01};
    vecs[7] = '{1'b1, 32'h0, 32'h80FF7F01, 2'd2, 1'b1, 32'h80FF7F01, 32'h80FF7F01};
    vecs[8] = '{1'b1, 32'h1, 32'h80FF7F01, 2'd3, 1'b0, 32'h80FF7F01, 32'h80FF7F01};
    vecs[9] = '{1'b0, 32'h12345672, 32'h80FF7F01, 2'd0, 1'b1, 32'h12345672, 32'h12345672};

    set_idle();
    rst = 1;
    #3 rst = 0;
    #1 check_outputs();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1;
    #1;

    // Single push with grant held high: visible next cycle, gone the cycle after.
    in_valid = 1; in_wb_en = 1; in_dest = 4'd3; in_alu_result = 32'h11; wb_gnt = 1;
    tick();
    in_valid = 0;
    chk("seq1_en", 32'(wb_en_out), 32'd1);
    chk("seq1_dest", 32'(wb_reg_dest_out), 32'd3);
    chk("seq1_val", wb_value_out, 32'h11);
    tick();
    chk("seq1_cnt", 32'(count), 32'd0);

    // Fill past capacity with grant low, then drain in order.
    wb_gnt = 0;
    for (int i = 0; i < 5; i++) begin
      push_alu(4'(i + 1), 32'h100 + 32'(i));
      if (i == 3) chk("full_ready", 32'(in_ready), 32'd0);
    end
    chk("full_cnt", 32'(count), 32'd4);
    wb_gnt = 1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_val", wb_value_out, 32'h100 + 32'(i));
      tick();
    end
    chk("drain_cnt", 32'(count), 32'd0);
    wb_gnt = 0;

    // Forwarding returns the youngest match.
    push_alu(4'd2, 32'hA);
    push_alu(4'd2, 32'hB);
    fwd_addr = 4'd2; #1;
    chk("fwd2_hit", 32'(fwd_hit), 32'd1);
    chk("fwd2_val", fwd_value, 32'hB);
    fwd_addr = 4'd7; #1;
    chk("fwd7_hit", 32'(fwd_hit), 32'd0);
    chk("fwd7_val", fwd_value, 32'h0);
    push_alu(4'd9, 32'hC);
    chk("pre_flush_cnt", 32'(count), 32'd3);

    // Flush beats a simultaneous push.
    flush = 1; in_valid = 1; in_wb_en = 1; in_alu_result = 32'h55;
    tick();
    flush = 0; in_valid = 0;
    chk("flush_cnt", 32'(count), 32'd0);
    chk("flush_en", 32'(wb_en_out), 32'd0);
    push_alu(4'd1, 32'h77);
    in_valid = 1; in_wb_en = 0; in_alu_result = 32'h88;
    tick();
    in_valid = 0;
    chk("nowb_cnt", 32'(count), 32'd1);
    flush = 1; tick(); flush = 0;

    // Load alignment vectors.
    for (int k = 0; k < 10; k++) begin
      in_valid = 1; in_wb_en = 1; in_dest = 4'(k); in_mem_r_en = vecs[k].mem_r_en;
      in_alu_result = vecs[k].alu; in_mem_data = vecs[k].mem;
      in_size = vecs[k].size; in_signed = vecs[k].sgn;
      tick();
      in_valid = 0;
`ifdef WB_LOAD_ALIGN_EN
      chk("align_vec", wb_value_out, vecs[k].exp_on);
`else
      chk("align_vec", wb_value_out, vecs[k].exp_off);
`endif
      flush = 1; tick(); flush = 0;
    end
    set_idle();

    // Asynchronous reset between edges with two entries queued.
    push_alu(4'd4, 32'h44);
    push_alu(4'd5, 32'h45);
    chk("prerst_cnt", 32'(count), 32'd2);
    #2 rst = 0;
    #1 mq.delete();
    chk("rst_en", 32'(wb_en_out), 32'd0);
    chk("rst_val", wb_value_out, 32'd0);
    check_outputs();
    #3 rst = 1;
    wb_gnt = 1;
    tick();
    chk("postrst_en", 32'(wb_en_out), 32'd0);
    tick();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      in_valid      = ($urandom_range(0, 9) < 7);
      in_wb_en      = ($urandom_range(0, 9) < 8);
      in_mem_r_en   = $urandom_range(0, 1) == 1;
      in_alu_result = $urandom;
      in_mem_data   = $urandom;
      in_dest       = 4'($urandom_range(0, 5));
      in_size       = 2'($urandom_range(0, 3));
      in_signed     = $urandom_range(0, 1) == 1;
      wb_gnt        = ($urandom_range(0, 9) < 5);
      flush         = ($urandom_range(0, 99) < 3);
      fwd_addr      = 4'($urandom_range(0, 6));
      tick();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
